ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage -- execute stage with registered EX/MEM outputs
//
// Single-cycle ALU ops (ADD, SUB, AND, NOR, OR, SLT) complete one edge after
// they are accepted.  When the macro EX_MULT_EN is defined, code 0110 starts
// an iterative shift-add multiply that holds the stage (busy) for WIDTH
// cycles.  Without EX_MULT_EN, 0110 is an undefined code (result 0), busy is
// tied low and the FSM never leaves IDLE.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous active-high reset
//   alu_ctl[3:0]   : ALU control code
//   a, b           : operands (WIDTH bits)
//   rd_in[4:0]     : destination register tag
//   reg_write_in   : write-enable tag
//   valid_in       : an operation is presented this cycle
//   flush          : kill the in-flight operation
//   result, zero, overflow, rd_out, reg_write_out, valid_out : EX/MEM register
//   busy           : a multiply holds the stage; upstream must stall
//   dbg_state[1:0] : current FSM state (0 IDLE, 1 MUL, 2 DONE)
//
// Handshake: an operation is taken on a rising edge where valid_in=1,
// busy=0, flush=0 and reset=0.  valid_out=1 marks the single cycle in which
// the registered outputs carry a completed operation; there is no
// back-pressure from downstream.
// ============================================================================
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rd_in,
    input  logic             reg_write_in,
    input  logic             valid_in,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [4:0]       rd_out,
    output logic             reg_write_out,
    output logic             valid_out,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;

`ifdef EX_MULT_EN
    localparam logic [3:0] OP_MUL = 4'b0110;
    localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0
    } state_t;
`endif

    state_t state, state_nx;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_ctl)
            OP_ADD: begin
                alu_res = sum;
                // operands of equal sign producing a result of the other sign
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_NOR: alu_res = ~(a | b);
            OP_OR:  alu_res = a | b;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic is_mul;
    logic start_mul;
    logic mul_fin;
    logic accept_single;

`ifdef EX_MULT_EN
    logic [WIDTH-1:0] m_acc, m_cand, m_plier, acc_step;
    logic [4:0]       m_rd;
    logic             m_rw;
    logic [CW-1:0]    cnt;

    assign is_mul   = (alu_ctl == OP_MUL);
    assign busy     = (state == MUL);
    // one shift-add iteration; on the last iteration this is the product
    assign acc_step = m_acc + (m_plier[0] ? m_cand : '0);

    always_comb begin
        state_nx  = state;
        start_mul = 1'b0;
        mul_fin   = 1'b0;
        case (state)
            // DONE only presents the product for one cycle; the stage is
            // free again, so a multiply offered in that cycle is taken
            // instead of being dropped.
            IDLE, DONE: begin
                if (valid_in && is_mul) begin
                    start_mul = 1'b1;
                    state_nx  = MUL;
                end else begin
                    state_nx  = IDLE;
                end
            end
            MUL: begin
                if (cnt == CW'(WIDTH-1)) begin
                    mul_fin  = 1'b1;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx  = IDLE;
            start_mul = 1'b0;
            mul_fin   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_acc   <= '0;
            m_cand  <= '0;
            m_plier <= '0;
            m_rd    <= '0;
            m_rw    <= 1'b0;
            cnt     <= '0;
        end else if (start_mul) begin
            // operands and tags are captured here so upstream may change
            // them freely while busy
            m_acc   <= '0;
            m_cand  <= a;
            m_plier <= b;
            m_rd    <= rd_in;
            m_rw    <= reg_write_in;
            cnt     <= '0;
        end else if (state == MUL) begin
            m_acc   <= acc_step;
            m_cand  <= m_cand << 1;
            m_plier <= m_plier >> 1;
            cnt     <= cnt + CW'(1);
        end
    end
`else
    assign is_mul    = 1'b0;
    assign busy      = 1'b0;
    assign start_mul = 1'b0;
    assign mul_fin   = 1'b0;

    always_comb begin
        state_nx = IDLE;
    end
`endif

    assign accept_single = valid_in && !is_mul && !busy && !flush;
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            result        <= '0;
            zero          <= 1'b0;
            overflow      <= 1'b0;
            rd_out        <= '0;
            reg_write_out <= 1'b0;
            valid_out     <= 1'b0;
        end else if (flush) begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
        end else if (accept_single) begin
            result        <= alu_res;
            zero          <= (alu_res == '0);
            overflow      <= alu_ovf;
            rd_out        <= rd_in;
            reg_write_out <= reg_write_in;
            valid_out     <= 1'b1;
        end else if (mul_fin) begin
`ifdef EX_MULT_EN
            result        <= acc_step;
            zero          <= (acc_step == '0);
            overflow      <= 1'b0;
            rd_out        <= m_rd;
            reg_write_out <= m_rw;
`endif
            valid_out     <= 1'b1;
        end else begin
            // no completing operation: the write tag is dropped so a
            // stale reg_write_out can never leak into MEM
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// ============================================================================
// tb_ex_stage -- randomized self-checking bench for ex_stage (WIDTH = 32).
// Expected values come from an arithmetic reference model; each accepted
// operation pushes its expected output into exp_q, popped when it completes.
// ============================================================================
module tb_ex_stage;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic [3:0]    alu_ctl;
    logic [W-1:0]  a, b;
    logic [4:0]    rd_in;
    logic          reg_write_in;
    logic          valid_in;
    logic          flush;
    logic [W-1:0]  result;
    logic          zero, overflow;
    logic [4:0]    rd_out;
    logic          reg_write_out, valid_out, busy;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    // {result[31:0], zero, overflow, rd[4:0], reg_write}
    logic [39:0] exp_q[$];

    ex_stage #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_ctl       (alu_ctl),
        .a             (a),
        .b             (b),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .valid_in      (valid_in),
        .flush         (flush),
        .result        (result),
        .zero          (zero),
        .overflow      (overflow),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .valid_out     (valid_out),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

`ifdef EX_MULT_EN
    localparam bit MULT = 1'b1;
`else
    localparam bit MULT = 1'b0;
`endif

    // ---------------- reference model ----------------
    function automatic logic [39:0] model(input logic [3:0] ctl, input logic [31:0] oa,
                                          input logic [31:0] ob, input logic [4:0] rd,
                                          input logic rw);
        longint sa, sb, s;
        longint unsigned p;
        logic [31:0] res;
        logic ovf;
        sa  = longint'($signed(oa));
        sb  = longint'($signed(ob));
        res = 32'd0;
        ovf = 1'b0;
        case (ctl)
            4'd0: begin
                s = sa + sb;
                res = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                s = sa - sb;
                res = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: res = oa & ob;
            4'd3: res = ~(oa | ob);
            4'd4: res = oa | ob;
            4'd5: res = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: begin
                p = 64'(oa) * 64'(ob);
                res = MULT ? p[31:0] : 32'd0;
            end
            default: res = 32'd0;
        endcase
        return {res, (res == 32'd0), ovf, rd, rw};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_out(input string tag);
        logic [39:0] e;
        check({tag, ".valid"}, 64'(valid_out), 64'd1);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".result"}, 64'(result), 64'(e[39:8]));
            check({tag, ".zero"}, 64'(zero), 64'(e[7]));
            check({tag, ".ovf"}, 64'(overflow), 64'(e[6]));
            check({tag, ".rd"}, 64'(rd_out), 64'(e[5:1]));
            check({tag, ".rw"}, 64'(reg_write_out), 64'(e[0]));
        end
    endtask

    // Called at a negedge; returns at the negedge where the op has completed.
    task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] oa,
                          input logic [31:0] ob, input logic [4:0] rd, input logic rw);
        exp_q.push_back(model(ctl, oa, ob, rd, rw));
        alu_ctl = ctl; a = oa; b = ob; rd_in = rd; reg_write_in = rw; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        if (MULT && ctl == 4'b0110) begin
            for (int i = 0; i < W; i++) begin
                check({tag, ".mul_busy"}, 64'(busy), 64'd1);
                check({tag, ".mul_nov"}, 64'(valid_out), 64'd0);
                // garbage offered while busy must be ignored and must not
                // disturb the latched operands
                if (i < W - 1) begin
                    alu_ctl = 4'($urandom_range(0, 6));
                    a = $urandom; b = $urandom; rd_in = 5'($urandom);
                    reg_write_in = 1'($urandom); valid_in = 1'b1;
                end else begin
                    valid_in = 1'b0;
                end
                @(negedge clk);
            end
        end
        check_out(tag);
    endtask

    task automatic idle_cycle(input string tag);
        valid_in = 1'b0;
        @(negedge clk);
        check({tag, ".idle_valid"}, 64'(valid_out), 64'd0);
        check({tag, ".idle_rw"}, 64'(reg_write_out), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rc;
        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; alu_ctl = '0;
        a = '0; b = '0; rd_in = '0; reg_write_in = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst.result", 64'(result), 64'd0);
        check("rst.zero", 64'(zero), 64'd0);
        check("rst.ovf", 64'(overflow), 64'd0);
        check("rst.rd", 64'(rd_out), 64'd0);
        check("rst.rw", 64'(reg_write_out), 64'd0);
        check("rst.valid", 64'(valid_out), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        idle_cycle("post_rst");

        // directed corner cases
        run_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1);
        idle_cycle("lat1");
        run_op("sub_zero", 4'b0001, 32'd5, 32'd5, 5'd4, 1'b1);
        run_op("slt_neg", 4'b0101, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b0);
        run_op("nor_zero", 4'b0011, 32'd0, 32'd0, 5'd6, 1'b1);
        run_op("undef_f", 4'b1111, 32'h1234, 32'h5678, 5'd7, 1'b1);
        run_op("sub_ovf", 4'b0001, 32'h8000_0000, 32'd1, 5'd8, 1'b1);
        run_op("mul_dir", 4'b0110, 32'd12345, 32'd678, 5'd9, 1'b1);
        idle_cycle("after_mul");

        // flush has priority over a simultaneous valid_in
        alu_ctl = 4'b0000; a = 32'd1; b = 32'd1; rd_in = 5'd1; reg_write_in = 1'b1;
        valid_in = 1'b1; flush = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b0;
        check("flush_prio.valid", 64'(valid_out), 64'd0);
        check("flush_prio.rw", 64'(reg_write_out), 64'd0);

        if (MULT) begin
            // flush at cycle 10 of a multiply
            alu_ctl = 4'b0110; a = 32'd99; b = 32'd77; rd_in = 5'd2; reg_write_in = 1'b1;
            valid_in = 1'b1;
            @(negedge clk);
            valid_in = 1'b0;
            repeat (9) @(negedge clk);
            check("mflush.busy_before", 64'(busy), 64'd1);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            check("mflush.valid", 64'(valid_out), 64'd0);
            check("mflush.rw", 64'(reg_write_out), 64'd0);
            check("mflush.busy", 64'(busy), 64'd0);
            check("mflush.state", 64'(dbg_state), 64'd0);
            for (int i = 0; i < W + 2; i++) begin
                @(negedge clk);
                if (valid_out !== 1'b0) check("mflush.late_valid", 64'(valid_out), 64'd0);
            end
            run_op("flush_add", 4'b0000, 32'd2, 32'd3, 5'd10, 1'b1);

            // reset mid-multiply overrides flush and valid_in
            alu_ctl = 4'b0110; a = 32'd1000; b = 32'd1000; rd_in = 5'd11; reg_write_in = 1'b1;
            valid_in = 1'b1;
            @(negedge clk);
            repeat (5) @(negedge clk);
            reset = 1'b1; flush = 1'b1;
            alu_ctl = 4'b0000;
            @(negedge clk);
            reset = 1'b0; flush = 1'b0; valid_in = 1'b0;
            check("mrst.result", 64'(result), 64'd0);
            check("mrst.valid", 64'(valid_out), 64'd0);
            check("mrst.rd", 64'(rd_out), 64'd0);
            check("mrst.rw", 64'(reg_write_out), 64'd0);
            check("mrst.busy", 64'(busy), 64'd0);
            check("mrst.state", 64'(dbg_state), 64'd0);
            for (int i = 0; i < W + 2; i++) begin
                @(negedge clk);
                if (valid_out !== 1'b0) check("mrst.late_valid", 64'(valid_out), 64'd0);
            end
        end else begin
            // without the multiplier, 0110 is an undefined single-cycle code
            run_op("mul_off", 4'b0110, 32'd7, 32'd6, 5'd12, 1'b1);
        end

        // randomized ops, back-to-back with occasional idle gaps
        for (int n = 0; n < 150; n++) begin
            rc = 4'($urandom_range(0, 15));
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? ra : pick();
            run_op("rand", rc, ra, rb, 5'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle("rand");
        end

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
